// File: rtl/mbist_port_sched_if.sv
// mbist_port_sched_if
//   Bundles every non-clock/reset signal of the memory-port scheduler:
//   host bus, BIST control/status, MBIST engine port, memory macro port and
//   the fault-log read interface.
//   Modports:
//     slave  - the scheduler (consumes host/engine/control, drives memory,
//              status and fault log)
//     master - the surrounding system (host, engine, repair logic, memory)
interface mbist_port_sched_if;
    // host bus
    logic        host_req;
    logic        host_we;
    logic [21:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_gnt;
    // BIST control / status
    logic        bist_start;
    logic        bist_abort;
    logic        bist_busy;
    logic        bist_done;
    logic        bist_pass;
    // MBIST engine
    logic        mb_test;
    logic        mb_early_term;
    logic        mb_ce;
    logic        mb_we;
    logic [21:0] mb_addr;
    logic [7:0]  mb_wdata;
    logic        mb_test_end;
    logic        mb_fault_detect;
    logic [21:0] mb_fault_addr;
    logic [7:0]  mb_fault_flag;
    // memory macro port
    logic        mem_ce;
    logic        mem_we;
    logic [21:0] mem_addr;
    logic [7:0]  mem_wdata;
    // fault log
    logic        flog_valid;
    logic        flog_ready;
    logic [29:0] flog_data;
    logic        flog_ovf;

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt,
        input  bist_start, bist_abort,
        output bist_busy, bist_done, bist_pass,
        output mb_test, mb_early_term,
        input  mb_ce, mb_we, mb_addr, mb_wdata, mb_test_end,
        input  mb_fault_detect, mb_fault_addr, mb_fault_flag,
        output mem_ce, mem_we, mem_addr, mem_wdata,
        output flog_valid, flog_data, flog_ovf,
        input  flog_ready
    );

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt,
        output bist_start, bist_abort,
        input  bist_busy, bist_done, bist_pass,
        input  mb_test, mb_early_term,
        output mb_ce, mb_we, mb_addr, mb_wdata, mb_test_end,
        output mb_fault_detect, mb_fault_addr, mb_fault_flag,
        input  mem_ce, mem_we, mem_addr, mem_wdata,
        input  flog_valid, flog_data, flog_ovf,
        output flog_ready
    );
endinterface

// File: rtl/mbist_port_sched.sv
// mbist_port_sched
//   Shares one memory port between the functional host and the MBIST engine.
//   The host owns the port while idle; a test request clears and launches the
//   engine, muxes its traffic onto the port and logs BIRA fault reports into a
//   small first-word-fall-through FIFO read back by repair logic.
//   Ports:
//     clk  - clock
//     rst  - synchronous active-low reset; all outputs forced low while 0
//     bus  - mbist_port_sched_if.slave (host, BIST ctrl, engine, memory, log)
//   Parameter:
//     FLOG_DEPTH - fault-log entries (power of two, >= 2)
module mbist_port_sched #(
    parameter int unsigned FLOG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    mbist_port_sched_if.slave bus
);
    localparam int unsigned AW = $clog2(FLOG_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FLUSH,
        S_DONE,
        S_ABORT
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    flush_cnt_q, flush_cnt_d;
    logic          fault_seen_q, fault_seen_d;
    logic          pass_q, pass_d;
    logic          ovf_q, ovf_d;
    logic          last_vld_q, last_vld_d;
    logic [21:0]   last_addr_q, last_addr_d;

    logic [29:0]   fifo_q [FLOG_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // internal (ungated) versions of the outputs
    logic          host_gnt_c, mem_ce_c, mem_we_c, mb_test_c, early_term_c;
    logic          done_c, pass_c;
    logic [21:0]   mem_addr_c;
    logic [7:0]    mem_wdata_c;

    logic          capture, push_req, push_ok, pop, full, valid, ovf_clr;

    assign full  = (cnt_q == CW'(FLOG_DEPTH));
    assign valid = (cnt_q != '0);

    // ---------------- FSM next state / port mux ----------------
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        fault_seen_d = fault_seen_q;
        pass_d       = pass_q;
        last_vld_d   = last_vld_q;
        last_addr_d  = last_addr_q;
        ovf_clr      = 1'b0;
        capture      = 1'b0;
        host_gnt_c   = 1'b0;
        mem_ce_c     = 1'b0;
        mem_we_c     = 1'b0;
        mem_addr_c   = '0;
        mem_wdata_c  = '0;
        mb_test_c    = 1'b0;
        early_term_c = 1'b0;
        done_c       = 1'b0;
        pass_c       = pass_q;

        unique case (state_q)
            S_IDLE: begin
                host_gnt_c  = bus.host_req & ~bus.bist_start;
                mem_ce_c    = host_gnt_c;
                mem_we_c    = bus.host_we;
                mem_addr_c  = bus.host_addr;
                mem_wdata_c = bus.host_wdata;
                if (bus.bist_start) begin
                    state_d      = S_PREP;
                    ovf_clr      = 1'b1;
                    fault_seen_d = 1'b0;
                    pass_d       = 1'b0;
                end
            end
            S_PREP: begin
                early_term_c = 1'b1;
                last_vld_d   = 1'b0;
                state_d      = S_RUN;
            end
            S_RUN: begin
                mb_test_c   = 1'b1;
                mem_ce_c    = bus.mb_ce;
                mem_we_c    = bus.mb_we;
                mem_addr_c  = bus.mb_addr;
                mem_wdata_c = bus.mb_wdata;
                capture     = bus.mb_fault_detect;
                flush_cnt_d = '0;
                if (bus.mb_test_end) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                // engine compare pipeline still reporting; keep test enabled
                mb_test_c = 1'b1;
                capture   = bus.mb_fault_detect;
                if (flush_cnt_q == 2'd2) state_d = S_DONE;
                else                     flush_cnt_d = flush_cnt_q + 2'd1;
            end
            S_DONE: begin
                done_c = 1'b1;
                pass_c = ~fault_seen_q;
                pass_d = ~fault_seen_q;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                early_term_c = 1'b1;
                done_c       = 1'b1;
                pass_c       = 1'b0;
                pass_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.bist_abort && (state_q inside {S_PREP, S_RUN, S_FLUSH}))
            state_d = S_ABORT;

        // Dedup against the last entry offered to the log; a dropped entry
        // (log full) still counts as "last pushed" so a repeat does not retry.
        push_req = capture &
                   ~(last_vld_q && (last_addr_q == bus.mb_fault_addr));
        if (capture) fault_seen_d = 1'b1;
        if (push_req) begin
            last_vld_d  = 1'b1;
            last_addr_d = bus.mb_fault_addr;
        end
    end

    // ---------------- fault-log FIFO control ----------------
    always_comb begin
        pop      = valid & bus.flog_ready;
        push_ok  = push_req & (~full | pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (ovf_clr)             ovf_d = 1'b0;
        if (push_req & ~push_ok) ovf_d = 1'b1;
        if (push_ok)             wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)                 rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop)     cnt_d = cnt_q + CW'(1);
        else if (!push_ok && pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            flush_cnt_q  <= '0;
            fault_seen_q <= 1'b0;
            pass_q       <= 1'b0;
            ovf_q        <= 1'b0;
            last_vld_q   <= 1'b0;
            last_addr_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            fault_seen_q <= fault_seen_d;
            pass_q       <= pass_d;
            ovf_q        <= ovf_d;
            last_vld_q   <= last_vld_d;
            last_addr_q  <= last_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push_ok)
            fifo_q[wr_ptr_q] <= {bus.mb_fault_addr, bus.mb_fault_flag};
    end

    // ---------------- outputs, all held low during reset ----------------
    assign bus.host_gnt      = rst & host_gnt_c;
    assign bus.mem_ce        = rst & mem_ce_c;
    assign bus.mem_we        = rst & mem_we_c;
    assign bus.mem_addr      = rst ? mem_addr_c  : '0;
    assign bus.mem_wdata     = rst ? mem_wdata_c : '0;
    assign bus.mb_test       = rst & mb_test_c;
    assign bus.mb_early_term = rst & early_term_c;
    assign bus.bist_busy     = rst & (state_q != S_IDLE);
    assign bus.bist_done     = rst & done_c;
    assign bus.bist_pass     = rst & pass_c;
    assign bus.flog_valid    = rst & valid;
    assign bus.flog_data     = rst ? fifo_q[rd_ptr_q] : '0;
    assign bus.flog_ovf      = rst & ovf_q;
endmodule

// File: tb/tb_mbist_port_sched.sv
// tb_mbist_port_sched
//   Directed sequence with randomized data for mbist_port_sched. A reference
//   model (phase counter + queue-based fault log) predicts every output each
//   cycle; directed steps add explicit checks at the key scenario points.
module tb_mbist_port_sched;
    localparam int unsigned DEPTH = 4;

    localparam int P_IDLE  = 0;
    localparam int P_PREP  = 1;
    localparam int P_RUN   = 2;
    localparam int P_FLUSH = 3;
    localparam int P_DONE  = 4;
    localparam int P_ABORT = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mbist_port_sched_if bus ();

    mbist_port_sched #(.FLOG_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    int          ph = P_IDLE;
    int          flush_left = 0;
    bit          m_seen = 1'b0;
    bit          m_pass = 1'b0;
    bit          m_ovf  = 1'b0;
    bit          m_lvld = 1'b0;
    logic [21:0] m_laddr = '0;
    logic [29:0] m_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_quiet();
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.bist_start = 1'b0; bus.bist_abort = 1'b0;
        bus.mb_ce = 1'b0; bus.mb_we = 1'b0; bus.mb_addr = '0; bus.mb_wdata = '0;
        bus.mb_test_end = 1'b0; bus.mb_fault_detect = 1'b0;
        bus.mb_fault_addr = '0; bus.mb_fault_flag = '0;
        bus.flog_ready = 1'b0;
    endtask

    task automatic rnd_host();
        bus.host_req   = 1'($urandom);
        bus.host_we    = 1'($urandom);
        bus.host_addr  = 22'($urandom);
        bus.host_wdata = 8'($urandom);
    endtask

    task automatic rnd_engine();
        bus.mb_ce    = 1'($urandom);
        bus.mb_we    = 1'($urandom);
        bus.mb_addr  = 22'($urandom);
        bus.mb_wdata = 8'($urandom);
    endtask

    task automatic fault(input bit det, input logic [21:0] a, input logic [7:0] f);
        bus.mb_fault_detect = det;
        bus.mb_fault_addr   = a;
        bus.mb_fault_flag   = f;
    endtask

    // compare every output against the model (inputs already applied)
    task automatic settle();
        logic        e_gnt, e_ce, e_we, e_busy, e_done, e_pass, e_test, e_et, e_valid, e_ovf;
        logic [21:0] e_addr;
        logic [7:0]  e_wd;
        logic [29:0] e_data;
        bit          idle, run;
        #2;
        idle   = (ph == P_IDLE);
        run    = (ph == P_RUN);
        e_gnt  = idle && bus.host_req && !bus.bist_start;
        e_ce   = idle ? e_gnt : (run ? bus.mb_ce : 1'b0);
        e_we   = idle ? bus.host_we : (run ? bus.mb_we : 1'b0);
        e_addr = idle ? bus.host_addr : (run ? bus.mb_addr : 22'h0);
        e_wd   = idle ? bus.host_wdata : (run ? bus.mb_wdata : 8'h0);
        e_busy = !idle;
        e_done = (ph == P_DONE) || (ph == P_ABORT);
        e_pass = (ph == P_DONE) ? !m_seen : ((ph == P_ABORT) ? 1'b0 : m_pass);
        e_test = run || (ph == P_FLUSH);
        e_et   = (ph == P_PREP) || (ph == P_ABORT);
        e_valid = (m_q.size() != 0);
        e_ovf  = m_ovf;
        e_data = (m_q.size() != 0) ? m_q[0] : 30'h0;
        if (!rst) begin
            e_gnt = 0; e_ce = 0; e_we = 0; e_addr = '0; e_wd = '0; e_busy = 0;
            e_done = 0; e_pass = 0; e_test = 0; e_et = 0; e_valid = 0; e_ovf = 0;
            e_data = '0;
        end
        chk("host_gnt",      32'(bus.host_gnt),      32'(e_gnt));
        chk("mem_ce",        32'(bus.mem_ce),        32'(e_ce));
        chk("mem_we",        32'(bus.mem_we),        32'(e_we));
        chk("mem_addr",      32'(bus.mem_addr),      32'(e_addr));
        chk("mem_wdata",     32'(bus.mem_wdata),     32'(e_wd));
        chk("bist_busy",     32'(bus.bist_busy),     32'(e_busy));
        chk("bist_done",     32'(bus.bist_done),     32'(e_done));
        chk("bist_pass",     32'(bus.bist_pass),     32'(e_pass));
        chk("mb_test",       32'(bus.mb_test),       32'(e_test));
        chk("mb_early_term", 32'(bus.mb_early_term), 32'(e_et));
        chk("flog_valid",    32'(bus.flog_valid),    32'(e_valid));
        chk("flog_ovf",      32'(bus.flog_ovf),      32'(e_ovf));
        if (e_valid || !rst)
            chk("flog_data", 32'(bus.flog_data), 32'(e_data));
    endtask

    // advance model and DUT across one rising edge
    task automatic adv();
        bit pop, cap, push;
        if (!rst) begin
            ph = P_IDLE; flush_left = 0; m_seen = 0; m_pass = 0; m_ovf = 0; m_lvld = 0;
            m_q.delete();
        end else begin
            pop  = (m_q.size() != 0) && bus.flog_ready;
            cap  = ((ph == P_RUN) || (ph == P_FLUSH)) && bus.mb_fault_detect;
            push = cap && !(m_lvld && (m_laddr == bus.mb_fault_addr));
            if (cap) m_seen = 1'b1;
            if (push) begin m_laddr = bus.mb_fault_addr; m_lvld = 1'b1; end
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < int'(DEPTH)) m_q.push_back({bus.mb_fault_addr, bus.mb_fault_flag});
                else                          m_ovf = 1'b1;
            end
            case (ph)
                P_IDLE:  if (bus.bist_start) begin ph = P_PREP; m_ovf = 0; m_seen = 0; m_pass = 0; end
                P_PREP:  begin m_lvld = 0; ph = bus.bist_abort ? P_ABORT : P_RUN; end
                P_RUN:   if (bus.bist_abort) ph = P_ABORT;
                         else if (bus.mb_test_end) begin ph = P_FLUSH; flush_left = 3; end
                P_FLUSH: if (bus.bist_abort) ph = P_ABORT;
                         else begin flush_left--; if (flush_left == 0) ph = P_DONE; end
                P_DONE:  begin m_pass = !m_seen; ph = P_IDLE; end
                default: begin m_pass = 1'b0; ph = P_IDLE; end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        settle();
        adv();
    endtask

    initial begin
        logic [21:0] base;
        int n;
        drive_quiet();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // reset: outputs low even with live host traffic
        repeat (3) begin rnd_host(); rnd_engine(); tick(); end
        rst = 1'b1;

        // host only, zero-latency grant
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 22'h0_0005; bus.host_wdata = 8'h3C;
        settle();
        chk("host_only_gnt",  32'(bus.host_gnt), 32'd1);
        chk("host_only_ce",   32'(bus.mem_ce),   32'd1);
        chk("host_only_addr", 32'(bus.mem_addr), 32'h5);
        adv();
        repeat (10) begin rnd_host(); rnd_engine(); tick(); end

        // start while host requests
        bus.host_req = 1'b1; bus.bist_start = 1'b1;
        settle();
        chk("start_gnt", 32'(bus.host_gnt), 32'd0);
        adv();
        bus.bist_start = 1'b0;
        settle();
        chk("prep_early_term", 32'(bus.mb_early_term), 32'd1);
        adv();
        settle();
        chk("run_mb_test", 32'(bus.mb_test),   32'd1);
        chk("run_busy",    32'(bus.bist_busy), 32'd1);
        adv();

        // clean run
        repeat (8) begin rnd_host(); rnd_engine(); tick(); end
        bus.mb_test_end = 1'b1; tick(); bus.mb_test_end = 1'b0;
        repeat (3) begin rnd_engine(); tick(); end
        settle();
        chk("clean_done",  32'(bus.bist_done),  32'd1);
        chk("clean_pass",  32'(bus.bist_pass),  32'd1);
        chk("clean_valid", 32'(bus.flog_valid), 32'd0);
        adv();

        // three distinct faults plus a repeat
        bus.flog_ready = 1'b0;
        bus.bist_start = 1'b1; tick(); bus.bist_start = 1'b0;
        tick();
        base = 22'($urandom);
        fault(1, base,          8'h10);        tick();
        fault(1, base + 22'd1,  8'($urandom)); tick();
        fault(1, base + 22'd2,  8'($urandom)); tick();
        fault(1, base + 22'd2,  8'($urandom)); tick();
        fault(0, '0, '0); rnd_engine(); tick();
        bus.mb_test_end = 1'b1; tick(); bus.mb_test_end = 1'b0;
        repeat (3) tick();
        settle();
        chk("fault_done",  32'(bus.bist_done),  32'd1);
        chk("fault_pass",  32'(bus.bist_pass),  32'd0);
        chk("fault_ovf",   32'(bus.flog_ovf),   32'd0);
        chk("fault_head",  32'(bus.flog_data),  32'({base, 8'h10}));
        adv();
        n = 0;
        bus.flog_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            settle();
            if (bus.flog_valid) n++;
            adv();
        end
        chk("fault_entries", 32'(n), 32'd3);
        bus.flog_ready = 1'b0;

        // overflow: six distinct faults into a four-entry log
        bus.bist_start = 1'b1; tick(); bus.bist_start = 1'b0;
        tick();
        base = 22'($urandom);
        for (int i = 0; i < 6; i++) begin
            fault(1, base + 22'(i), 8'($urandom)); rnd_engine(); tick();
        end
        fault(0, '0, '0);
        bus.mb_test_end = 1'b1; tick(); bus.mb_test_end = 1'b0;
        repeat (3) tick();
        settle();
        chk("ovf_set",  32'(bus.flog_ovf),  32'd1);
        chk("ovf_pass", 32'(bus.bist_pass), 32'd0);
        adv();

        // restart clears overflow; then abort mid-run
        bus.bist_start = 1'b1; tick(); bus.bist_start = 1'b0;
        settle();
        chk("ovf_cleared", 32'(bus.flog_ovf), 32'd0);
        adv();
        repeat (3) begin rnd_engine(); tick(); end
        bus.bist_abort = 1'b1; tick(); bus.bist_abort = 1'b0;
        settle();
        chk("abort_early_term", 32'(bus.mb_early_term), 32'd1);
        chk("abort_done",       32'(bus.bist_done),     32'd1);
        chk("abort_pass",       32'(bus.bist_pass),     32'd0);
        adv();
        bus.host_req = 1'b1;
        settle();
        chk("abort_host_gnt", 32'(bus.host_gnt), 32'd1);
        adv();
        n = 0;
        bus.flog_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            settle();
            if (bus.flog_valid) n++;
            adv();
        end
        chk("ovf_entries", 32'(n), 32'd4);

        // reset mid-run
        bus.bist_start = 1'b1; tick(); bus.bist_start = 1'b0;
        repeat (3) begin rnd_engine(); fault(1, 22'($urandom), 8'($urandom)); tick(); end
        rst = 1'b0;
        settle();
        chk("rst_mb_test", 32'(bus.mb_test),  32'd0);
        chk("rst_busy",    32'(bus.bist_busy), 32'd0);
        adv();
        rst = 1'b1;
        fault(0, '0, '0);
        settle();
        chk("rst_after_busy",  32'(bus.bist_busy),  32'd0);
        chk("rst_after_valid", 32'(bus.flog_valid), 32'd0);
        adv();

        // randomized traffic
        base = 22'($urandom);
        for (int i = 0; i < 400; i++) begin
            rnd_host();
            rnd_engine();
            bus.bist_start      = ($urandom_range(0, 19) == 0);
            bus.bist_abort      = ($urandom_range(0, 49) == 0);
            bus.mb_test_end     = ($urandom_range(0, 14) == 0);
            fault(($urandom_range(0, 2) == 0), base + 22'($urandom_range(0, 5)), 8'($urandom));
            bus.flog_ready      = ($urandom_range(0, 3) == 0);
            rst                 = !($urandom_range(0, 149) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
